// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller; CACHE_CWF_EN selects critical-word-first ordering
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [15:0]                    miss_address,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           mem_en,
    output logic [15:0]                    memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           write_tag_array
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [15:0]      OFF_MASK = 16'((1 << OFF_W) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [15:0]        base_addr;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   recv_cnt;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   miss_word;
    logic [IDX_W-1:0]   issue_word;
    logic [IDX_W-1:0]   recv_word;

    // Word slot where the fill order begins for a new miss.
`ifdef CACHE_CWF_EN
    assign miss_word = miss_address[OFF_W-1:1];
`else
    assign miss_word = '0;
`endif

    // Offsets wrap inside the block because the sum is truncated to IDX_W bits.
    assign issue_word = start_idx + issue_cnt[IDX_W-1:0];
    assign recv_word  = start_idx + recv_cnt[IDX_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Block base, start word and issue/receive counters; re-armed on every IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr <= '0;
            start_idx <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base_addr <= miss_address & ~OFF_MASK;
                start_idx <= miss_word;
            end
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (mem_en) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (write_data_array) begin
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

    // Next state: a miss starts a fill; the last returning word ends it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (write_tag_array) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state, counters and the memory valid with no added latency.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_idx    = '0;
        write_tag_array  = 1'b0;
        if (state == FILL) begin
            fsm_busy = 1'b1;
            if (issue_cnt != FULL) begin
                mem_en         = 1'b1;
                memory_address = base_addr | {{(16 - OFF_W){1'b0}}, issue_word, 1'b0};
            end
            if (memory_data_valid && (recv_cnt != FULL)) begin
                write_data_array = 1'b1;
                fill_word_idx    = recv_word;
                write_tag_array  = (recv_cnt == LAST);
            end
        end
    end

endmodule
